// File: rtl/mc_cpu_core.sv
`default_nettype none
// =============================================================================
// Module : mc_cpu_core
// Multi-cycle 16-bit-ISA core, single shared ALU, req/ready instruction/data ports.
// Rev    : 1.0
// =============================================================================
module mc_cpu_core #(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [15:0]       imem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ready,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              halted,
   output logic [ADDR_W-1:0] pc_dbg
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_ADDI = 4'd5;
   localparam logic [3:0] OP_LD   = 4'd6;
   localparam logic [3:0] OP_ST   = 4'd7;
   localparam logic [3:0] OP_JMP  = 4'd8;
   localparam logic [3:0] OP_BR   = 4'd9;
   localparam logic [3:0] OP_HALT = 4'd15;
   localparam int         MSB     = DATA_W - 1;

   state_t            state;
   logic [15:0]       ir;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] regs [8];
   logic [DATA_W-1:0] opa, opb, opd, result;
   logic              flag_z, flag_c, flag_s, flag_o;

   logic [3:0]        op;
   logic [2:0]        rd;
   logic [DATA_W-1:0] simm, alu_b, alu_res;
   logic [DATA_W:0]   sum, diff;
   logic              alu_c, alu_o, br_taken;

   assign op        = ir[15:12];
   assign rd        = ir[11:9];
   assign simm      = {{(DATA_W-6){ir[5]}}, ir[5:0]};
   assign imem_addr = pc;
   assign pc_dbg    = pc;

   // One adder serves ADD, ADDI and the LD/ST effective address.
   always_comb begin
      alu_b   = (op == OP_ADDI || op == OP_LD || op == OP_ST) ? simm : opb;
      sum     = {1'b0, opa} + {1'b0, alu_b};
      diff    = {1'b0, opa} - {1'b0, opb};
      alu_res = sum[DATA_W-1:0];
      alu_c   = sum[DATA_W];
      alu_o   = (opa[MSB] == alu_b[MSB]) && (sum[MSB] != opa[MSB]);
      case (op)
         OP_SUB: begin
            alu_res = diff[DATA_W-1:0];
            alu_c   = diff[DATA_W];
            alu_o   = (opa[MSB] != opb[MSB]) && (diff[MSB] != opa[MSB]);
         end
         OP_AND: begin alu_res = opa & opb; alu_c = 1'b0; alu_o = 1'b0; end
         OP_OR:  begin alu_res = opa | opb; alu_c = 1'b0; alu_o = 1'b0; end
         OP_XOR: begin alu_res = opa ^ opb; alu_c = 1'b0; alu_o = 1'b0; end
         default: ;
      endcase
   end

   always_comb begin
      case (rd)
         3'd0:    br_taken = 1'b1;
         3'd1:    br_taken = flag_z;
         3'd2:    br_taken = flag_c;
         3'd3:    br_taken = ~flag_z & ~flag_c;
         3'd4:    br_taken = flag_s ^ flag_o;
         3'd5:    br_taken = ~flag_z & ~(flag_s ^ flag_o);
         default: br_taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_FETCH;
         pc         <= RESET_PC;
         ir         <= '0;
         opa        <= '0;
         opb        <= '0;
         opd        <= '0;
         result     <= '0;
         flag_z     <= 1'b0;
         flag_c     <= 1'b0;
         flag_s     <= 1'b0;
         flag_o     <= 1'b0;
         imem_req   <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         halted     <= 1'b0;
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else begin
         case (state)
            // Only the first fetch after reset raises req here; later entries arrive with it set.
            S_FETCH: begin
               if (!imem_req) begin
                  imem_req <= 1'b1;
               end else if (imem_ready) begin
                  ir       <= imem_rdata;
                  pc       <= pc + ADDR_W'(1);
                  imem_req <= 1'b0;
                  state    <= S_DECODE;
               end
            end
            S_DECODE: begin
               opa   <= regs[ir[8:6]];
               opb   <= regs[ir[5:3]];
               opd   <= regs[rd];
               state <= S_EXEC;
            end
            S_EXEC: begin
               state    <= S_FETCH;
               imem_req <= 1'b1;
               case (op)
                  OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: begin
                     result   <= alu_res;
                     flag_z   <= (alu_res == '0);
                     flag_s   <= alu_res[MSB];
                     flag_c   <= alu_c;
                     flag_o   <= alu_o;
                     imem_req <= 1'b0;
                     state    <= S_WB;
                  end
                  OP_LD, OP_ST: begin
                     dmem_req   <= 1'b1;
                     dmem_we    <= (op == OP_ST);
                     dmem_addr  <= sum[ADDR_W-1:0];
                     dmem_wdata <= opd;
                     imem_req   <= 1'b0;
                     state      <= S_MEM;
                  end
                  OP_JMP: pc <= ir[ADDR_W-1:0];
                  OP_BR: begin
                     if (br_taken) pc <= ir[ADDR_W-1:0];
                  end
                  OP_HALT: begin
                     imem_req <= 1'b0;
                     halted   <= 1'b1;
                     state    <= S_HALT;
                  end
                  default: ;
               endcase
            end
            S_MEM: begin
               if (dmem_ready) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  if (dmem_we) begin
                     imem_req <= 1'b1;
                     state    <= S_FETCH;
                  end else begin
                     result <= dmem_rdata;
                     state  <= S_WB;
                  end
               end
            end
            S_WB: begin
               regs[rd] <= result;
               imem_req <= 1'b1;
               state    <= S_FETCH;
            end
            S_HALT: halted <= 1'b1;
            default: state <= S_FETCH;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mc_cpu_core.sv
`default_nettype none
// =============================================================================
// Module : tb_mc_cpu_core
// Directed instruction-trace bench for mc_cpu_core (8-bit and 16-bit builds).
// Rev    : 1.0
// =============================================================================
module tb_mc_cpu_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- 8-bit core, reset vector 0x40 ----------------
   logic        rst;
   logic        imem_req, imem_ready;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic        dmem_req, dmem_we, dmem_ready;
   logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
   logic        halted;
   logic [7:0]  pc_dbg;

   logic [15:0] imem [256];
   logic [7:0]  dmem [256];
   bit          dval [256];
   bit          ihold = 1'b1;
   int          dwait = 0;
   int          dcnt  = 0;
   int          st_cnt = 0;
   logic [7:0]  st_addr, st_data;

   assign imem_ready = imem_req && !ihold;
   assign imem_rdata = imem[imem_addr];
   assign dmem_ready = dmem_req && (dcnt >= dwait);
   assign dmem_rdata = dval[dmem_addr] ? dmem[dmem_addr] : (dmem_addr ^ 8'hA5);

   always @(posedge clk) begin
      if (dmem_req && !dmem_ready) dcnt <= dcnt + 1;
      else                         dcnt <= 0;
      if (dmem_req && dmem_ready && dmem_we) begin
         dmem[dmem_addr] <= dmem_wdata;
         dval[dmem_addr] <= 1'b1;
         st_cnt          <= st_cnt + 1;
         st_addr         <= dmem_addr;
         st_data         <= dmem_wdata;
      end
   end

   mc_cpu_core #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'h40)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .halted(halted), .pc_dbg(pc_dbg)
   );

   // ---------------- 16-bit core, reset vector 0 ----------------
   logic        rst_h;
   logic        imem_req_h, imem_ready_h;
   logic [7:0]  imem_addr_h;
   logic [15:0] imem_rdata_h;
   logic        dmem_req_h, dmem_we_h, dmem_ready_h;
   logic [7:0]  dmem_addr_h;
   logic [15:0] dmem_wdata_h, dmem_rdata_h;
   logic        halted_h;
   logic [7:0]  pc_dbg_h;
   logic [15:0] imem_h [256];
   logic [7:0]  fa_h [$];
   int          st_cnt_h = 0;
   logic [7:0]  st_addr_h;
   logic [15:0] st_data_h;

   assign imem_ready_h = imem_req_h;
   assign imem_rdata_h = imem_h[imem_addr_h];
   assign dmem_ready_h = dmem_req_h;
   assign dmem_rdata_h = (dmem_addr_h == 8'h00) ? 16'h7FFF : 16'h0000;

   always @(posedge clk) begin
      if (imem_req_h && imem_ready_h) fa_h.push_back(imem_addr_h);
      if (dmem_req_h && dmem_ready_h && dmem_we_h) begin
         st_cnt_h  <= st_cnt_h + 1;
         st_addr_h <= dmem_addr_h;
         st_data_h <= dmem_wdata_h;
      end
   end

   mc_cpu_core #(.DATA_W(16), .ADDR_W(8)) dut_h (
      .clk(clk), .rst(rst_h),
      .imem_req(imem_req_h), .imem_addr(imem_addr_h), .imem_ready(imem_ready_h), .imem_rdata(imem_rdata_h),
      .dmem_req(dmem_req_h), .dmem_we(dmem_we_h), .dmem_addr(dmem_addr_h), .dmem_wdata(dmem_wdata_h),
      .dmem_ready(dmem_ready_h), .dmem_rdata(dmem_rdata_h), .halted(halted_h), .pc_dbg(pc_dbg_h)
   );

   // ---------------- encoders and vector table ----------------
   function automatic logic [15:0] er(int op, int rd, int rs1, int rs2);
      return {op[3:0], rd[2:0], rs1[2:0], rs2[2:0], 3'b000};
   endfunction
   function automatic logic [15:0] ei(int op, int rd, int rs1, int imm);
      return {op[3:0], rd[2:0], rs1[2:0], imm[5:0]};
   endfunction
   function automatic logic [15:0] eb(int cond, int tgt);
      return {4'd9, cond[2:0], tgt[8:0]};
   endfunction
   function automatic logic [15:0] ej(int tgt);
      return {4'd8, 3'd0, tgt[8:0]};
   endfunction

   typedef struct {
      logic [7:0]  pc;
      logic [15:0] instr;
      int          cycles;
      int          dw;
      bit          st;
      logic [7:0]  sa;
      logic [7:0]  sd;
   } vec_t;
   vec_t vecs [$];

   task automatic vs(input logic [7:0] pc, input logic [15:0] ins, input int cy, input int dw,
                     input bit st, input logic [7:0] sa, input logic [7:0] sd);
      vec_t e;
      e.pc = pc; e.instr = ins; e.cycles = cy; e.dw = dw; e.st = st; e.sa = sa; e.sd = sd;
      vecs.push_back(e);
   endtask
   task automatic v(input logic [7:0] pc, input logic [15:0] ins, input int cy, input int dw);
      vs(pc, ins, cy, dw, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Predicts an accepted fetch at the coming rising edge; returns just after that edge.
   task automatic wait_fetch(output int t, output logic [7:0] a, output bit ok);
      ok = 1'b0; t = 0; a = 8'h00;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (imem_req && imem_ready) begin
            t = cyc; a = imem_addr; ok = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int         t_prev, t, s0, nreq;
      logic [7:0] a;
      bit         ok;
      logic [7:0] exp_h [7];

      // r1=FF r2=FE r3=FF r4=00 r5=01 r6=01 r7=00 r0 -> E0,C0,80,7F
      v (8'h40, ei(5,1,0,-1),   4, 0);
      v (8'h41, er(0,2,1,1),    4, 0);
      v (8'h42, eb(2,'h50),     3, 0);
      v (8'h50, eb(1,'h70),     3, 0);
      v (8'h51, eb(4,'h54),     3, 0);
      vs(8'h54, ei(7,2,0,5),    4, 0, 1'b1, 8'h05, 8'hFE);
      vs(8'h55, ei(7,1,0,5),    6, 2, 1'b1, 8'h05, 8'hFF);
      v (8'h56, ei(6,3,0,5),    7, 2);
      vs(8'h57, ei(7,3,1,7),    4, 0, 1'b1, 8'h06, 8'hFF);
      v (8'h58, er(1,4,1,1),    4, 0);
      v (8'h59, eb(1,'h60),     3, 0);
      v (8'h60, eb(2,'h70),     3, 0);
      v (8'h61, eb(3,'h70),     3, 0);
      v (8'h62, er(1,5,0,1),    4, 0);
      v (8'h63, eb(2,'h68),     3, 0);
      v (8'h68, er(4,6,2,1),    4, 0);
      v (8'h69, eb(3,'h6C),     3, 0);
      v (8'h6C, er(2,7,2,5),    4, 0);
      v (8'h6D, eb(5,'h70),     3, 0);
      v (8'h6E, ei(5,0,0,-32),  4, 0);
      v (8'h6F, er(0,0,0,0),    4, 0);
      v (8'h70, er(0,0,0,0),    4, 0);
      v (8'h71, er(1,0,0,6),    4, 0);
      v (8'h72, eb(4,'h75),     3, 0);
      v (8'h75, eb(5,'h78),     3, 0);
      vs(8'h76, ei(7,0,6,0),    4, 0, 1'b1, 8'h01, 8'h7F);
      vs(8'h77, ei(7,7,0,-1),   4, 0, 1'b1, 8'h7E, 8'h00);
      v (8'h78, eb(6,'h10),     3, 0);
      v (8'h79, eb(7,'h10),     3, 0);
      v (8'h7A, 16'hA000,       3, 0);
      v (8'h7B, eb(0,'h90),     3, 0);
      v (8'h90, ej('h1FF),      3, 0);
      v (8'hFF, 16'hE000,       3, 0);
      v (8'h00, ei(6,1,6,31),   5, 0);
      vs(8'h01, ei(7,1,5,9),    4, 0, 1'b1, 8'h0A, 8'h85);
      v (8'h02, 16'hF000,       0, 0);

      for (int i = 0; i < 256; i++) begin
         imem[i]   = 16'hF000;
         imem_h[i] = 16'hF000;
      end
      foreach (vecs[i]) imem[vecs[i].pc] = vecs[i].instr;
      imem_h[0] = ei(5,1,0,1);
      imem_h[1] = ei(6,2,0,0);
      imem_h[2] = er(0,3,2,1);
      imem_h[3] = ei(7,3,0,2);
      imem_h[4] = eb(2,'h20);
      imem_h[5] = eb(5,'h30);

      rst = 1'b1; rst_h = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_imem_req", imem_req, 0);
      chk("reset_dmem_req", dmem_req, 0);
      chk("reset_halted",   halted,   0);
      chk("reset_pc",       pc_dbg,   8'h40);

      // Reset arriving while a fetch is stalled
      @(negedge clk) rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("stalled_fetch_req", imem_req, 1);
      #2 rst = 1'b1;
      #1 chk("async_reset_req", imem_req, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      chk("post_reset_req",  imem_req,  1);
      chk("post_reset_addr", imem_addr, 8'h40);
      ihold = 1'b0;

      wait_fetch(t_prev, a, ok);
      chk("first_fetch_ok",   ok, 1);
      chk("first_fetch_addr", a,  vecs[0].pc);
      for (int i = 0; i < vecs.size() - 1; i++) begin
         dwait = vecs[i].dw;
         s0    = st_cnt;
         wait_fetch(t, a, ok);
         if (!ok) t = t_prev + 999;
         chk($sformatf("v%0d_latency", i), t - t_prev, vecs[i].cycles);
         chk($sformatf("v%0d_next_pc", i), a, vecs[i+1].pc);
         chk($sformatf("v%0d_store_count", i), st_cnt - s0, vecs[i].st ? 1 : 0);
         if (vecs[i].st) begin
            chk($sformatf("v%0d_store_addr", i), st_addr, vecs[i].sa);
            chk($sformatf("v%0d_store_data", i), st_data, vecs[i].sd);
         end
         t_prev = t;
      end

      repeat (4) @(posedge clk);
      #1;
      chk("halted_flag", halted, 1);
      chk("halt_pc",     pc_dbg, 8'h03);
      nreq = 0;
      repeat (20) begin
         @(negedge clk);
         if (imem_req || dmem_req) nreq++;
      end
      chk("halt_no_requests", nreq, 0);

      // 16-bit build: 0x7FFF + 1 must set O and S, clear C
      @(negedge clk) rst_h = 1'b0;
      for (int k = 0; k < 300 && !halted_h; k++) @(negedge clk);
      chk("w16_halted", halted_h, 1);
      exp_h = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h30};
      chk("w16_fetch_count", fa_h.size(), 7);
      for (int i = 0; i < 7; i++)
         chk($sformatf("w16_fetch%0d", i), (i < fa_h.size()) ? fa_h[i] : 8'hXX, exp_h[i]);
      chk("w16_store_count", st_cnt_h,  1);
      chk("w16_store_addr",  st_addr_h, 8'h02);
      chk("w16_store_data",  st_data_h, 16'h8000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
